// File: rtl/crtc_bus_master_if.sv
// Host request/response port and MC6845 CPU-side bus, grouped for crtc_bus_master.
// master: the bus master's view; slave: the host/CRTC side.
interface crtc_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       CSn;
  logic       E;
  logic       RS;
  logic       RW;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] D_in;

  modport master (
    input  req_valid, req_rw, req_addr, req_data, D_in,
    output req_ready, rsp_valid, rsp_data, CSn, E, RS, RW, D_out, D_oe
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data, D_in,
    input  req_ready, rsp_valid, rsp_data, CSn, E, RS, RW, D_out, D_oe
  );
endinterface

// File: rtl/crtc_bus_master.sv
// MC6845 register-interface initiator: host single reads/writes plus an init table loader.
// Optional CRTC_READBACK_VERIFY_EN reads back R14/R15 after init and flags mismatches on init_err.
module crtc_bus_master #(
  parameter int unsigned E_HALF     = 1,
  parameter int unsigned INIT_COUNT = 16
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic init_start,
  output logic init_busy,
  output logic init_done,
  output logic init_err,
  crtc_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, A_EH, A_EL, D_EH, D_EL, RESP
`ifdef CRTC_READBACK_VERIFY_EN
    , CHK_EH, CHK_EL
`endif
  } state_t;

  localparam logic [7:0] R14_REF = 8'h00;
  localparam logic [7:0] R15_REF = 8'h00;

  function automatic logic [7:0] init_value(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'h5E;
      4'd1:    v = 8'h4C;
      4'd2:    v = 8'h4E;
      4'd3:    v = 8'h0C;
      4'd4:    v = 8'h40;
      4'd5:    v = 8'h05;
      4'd6:    v = 8'h3C;
      4'd7:    v = 8'h3D;
      4'd9:    v = 8'h07;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t     state, state_next;
  logic [7:0] cnt;
  logic       last;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       rw;
  logic [7:0] rd_byte;
  logic       ready_en;
  logic       init_go;
  logic       req_go;
  logic       last_entry;

  assign last       = (cnt == 8'(E_HALF - 1));
  assign last_entry = (addr == 5'(INIT_COUNT - 1));
  assign init_go    = (state == IDLE) && init_start;
  // Ready is withheld while init_start is high so a simultaneous host request simply waits.
  assign bus.req_ready = ready_en && (state == IDLE) && !init_busy && !init_start;
  assign req_go     = bus.req_valid && bus.req_ready;

`ifdef CRTC_READBACK_VERIFY_EN
  logic chk_reg;
  logic chk_data;
  logic err_q;
  assign init_err = err_q;
`else
  assign init_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.CSn       = 1'b1;
    bus.E         = 1'b0;
    bus.RS        = 1'b0;
    bus.RW        = 1'b1;
    bus.D_oe      = 1'b0;
    bus.D_out     = 8'h00;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    case (state)
      IDLE: begin
        if (init_go || req_go) state_next = A_EH;
      end
      A_EH, A_EL: begin
        bus.CSn   = 1'b0;
        bus.RW    = 1'b0;
        bus.D_oe  = 1'b1;
        bus.D_out = {3'b000, addr};
        bus.E     = (state == A_EH);
        if (last) state_next = (state == A_EH) ? A_EL : D_EH;
      end
      D_EH, D_EL: begin
        bus.CSn   = 1'b0;
        bus.RS    = 1'b1;
        bus.RW    = rw;
        bus.D_oe  = !rw;
        bus.D_out = rw ? 8'h00 : wdata;
        bus.E     = (state == D_EH);
        if (last) begin
          if (state == D_EH)  state_next = D_EL;
          else if (!init_busy) state_next = RESP;
          else if (!last_entry) state_next = A_EH;
          else begin
`ifdef CRTC_READBACK_VERIFY_EN
            state_next = CHK_EH;
`else
            state_next = IDLE;
`endif
          end
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rw ? rd_byte : 8'h00;
        state_next    = IDLE;
      end
`ifdef CRTC_READBACK_VERIFY_EN
      // Each check register takes an address half (RS=0 write) then a data half (RS=1 read).
      CHK_EH, CHK_EL: begin
        bus.CSn = 1'b0;
        bus.E   = (state == CHK_EH);
        if (chk_data) begin
          bus.RS = 1'b1;
        end else begin
          bus.RW    = 1'b0;
          bus.D_oe  = 1'b1;
          bus.D_out = chk_reg ? 8'h0F : 8'h0E;
        end
        if (last) begin
          if (state == CHK_EH)          state_next = CHK_EL;
          else if (chk_data && chk_reg) state_next = IDLE;
          else                          state_next = CHK_EH;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt       <= 8'd0;
      addr      <= 5'd0;
      wdata     <= 8'h00;
      rw        <= 1'b0;
      rd_byte   <= 8'h00;
      ready_en  <= 1'b0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
`ifdef CRTC_READBACK_VERIFY_EN
      chk_reg   <= 1'b0;
      chk_data  <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      cnt      <= (state_next == state && state != IDLE) ? cnt + 8'd1 : 8'd0;
      case (state)
        IDLE: begin
          if (init_go) begin
            init_busy <= 1'b1;
            init_done <= 1'b0;
`ifdef CRTC_READBACK_VERIFY_EN
            err_q     <= 1'b0;
`endif
            addr      <= 5'd0;
            wdata     <= init_value(4'd0);
            rw        <= 1'b0;
          end else if (req_go) begin
            rw    <= bus.req_rw;
            addr  <= bus.req_addr;
            wdata <= bus.req_data;
          end
        end
        D_EH: begin
          if (last && rw) rd_byte <= bus.D_in;
        end
        D_EL: begin
          if (last && init_busy) begin
            if (!last_entry) begin
              addr  <= addr + 5'd1;
              wdata <= init_value(addr[3:0] + 4'd1);
            end else begin
`ifdef CRTC_READBACK_VERIFY_EN
              chk_reg  <= 1'b0;
              chk_data <= 1'b0;
`else
              init_busy <= 1'b0;
              init_done <= 1'b1;
`endif
            end
          end
        end
`ifdef CRTC_READBACK_VERIFY_EN
        CHK_EH: begin
          if (last && chk_data) rd_byte <= bus.D_in;
        end
        CHK_EL: begin
          if (last) begin
            if (!chk_data) begin
              chk_data <= 1'b1;
            end else if (!chk_reg) begin
              if (rd_byte[5:0] != R14_REF[5:0]) err_q <= 1'b1;
              chk_reg  <= 1'b1;
              chk_data <= 1'b0;
            end else begin
              if (rd_byte != R15_REF) err_q <= 1'b1;
              init_busy <= 1'b0;
              init_done <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crtc_bus_master.sv
// Directed bench for crtc_bus_master: host reads/writes, init table load, reset abort, latency.
// Honours CRTC_READBACK_VERIFY_EN to exercise the readback check when the design is built with it.
module tb_crtc_bus_master;

`ifdef CRTC_READBACK_VERIFY_EN
  localparam int INIT_CYC = 72;
`else
  localparam int INIT_CYC = 64;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  crtc_bus_master_if bus1();
  crtc_bus_master_if bus3();

  logic init_start1, init_busy1, init_done1, init_err1;
  logic init_start3, init_busy3, init_done3, init_err3;

  crtc_bus_master #(.E_HALF(1), .INIT_COUNT(16)) dut1 (
    .CLK(clk), .RSTn(rst_n), .init_start(init_start1), .init_busy(init_busy1),
    .init_done(init_done1), .init_err(init_err1), .bus(bus1)
  );

  crtc_bus_master #(.E_HALF(3), .INIT_COUNT(16)) dut3 (
    .CLK(clk), .RSTn(rst_n), .init_start(init_start3), .init_busy(init_busy3),
    .init_done(init_done3), .init_err(init_err3), .bus(bus3)
  );

  // Tiny MC6845 model: address latch plus register file, written on the falling edge of E.
  logic [7:0]  regs [0:31];
  logic [4:0]  ar = 5'd0;
  logic        force_r15 = 1'b0;
  logic [12:0] wlog [0:127];
  int          wlog_n = 0;
  int          e_rises = 0;

  always @(negedge bus1.E) begin
    if (!bus1.CSn && !bus1.RW) begin
      if (!bus1.RS) begin
        ar <= bus1.D_out[4:0];
      end else begin
        regs[ar]     <= bus1.D_out;
        wlog[wlog_n] <= {ar, bus1.D_out};
        wlog_n       <= wlog_n + 1;
      end
    end
  end

  always @(posedge bus1.E) e_rises = e_rises + 1;

  assign bus1.D_in = (force_r15 && ar == 5'd15) ? 8'h01 : regs[ar];
  assign bus3.D_in = 8'hAD;

  logic [7:0] init_tab [0:15] = '{8'h5E, 8'h4C, 8'h4E, 8'h0C, 8'h40, 8'h05, 8'h3C, 8'h3D,
                                  8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One host transaction on the E_HALF=1 instance, checking both bus phases and the response.
  task automatic applyStimulus(input logic rw, input logic [4:0] addr, input logic [7:0] data,
                               input logic [7:0] exp_rsp);
    int  k;
    bit  seen;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_rw    = rw;
    bus1.req_addr  = addr;
    bus1.req_data  = data;
    k = 0;
    while (!bus1.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("req_ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    k    = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (k == 1)
        checkOutput("a_phase", {bus1.CSn, bus1.E, bus1.RS, bus1.RW, bus1.D_oe, bus1.D_out},
                    {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, addr});
      if (k == 3)
        checkOutput("d_phase", {bus1.CSn, bus1.E, bus1.RS, bus1.RW, bus1.D_oe, bus1.D_out},
                    {1'b0, 1'b1, 1'b1, rw, ~rw, (rw ? 8'h00 : data)});
      if (bus1.rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput("rsp_latency", 32'(k), 32'd5);
    checkOutput("rsp_data", 32'(bus1.rsp_data), 32'(exp_rsp));
    @(negedge clk);
    checkOutput("rsp_pulse", 32'(bus1.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput(tag, {bus1.CSn, bus1.E, bus1.RS, bus1.RW, bus1.D_oe, bus1.D_out,
                      bus1.req_ready, bus1.rsp_valid, bus1.rsp_data},
                {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic run_init(output int busy_cycles);
    @(negedge clk);
    init_start1 = 1'b1;
    @(negedge clk);
    init_start1 = 1'b0;
    busy_cycles = 0;
    while (init_busy1 && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  k;
    int  base;
    int  cyc;
    bit  rsp_seen;
    init_start1    = 1'b0;
    init_start3    = 1'b0;
    bus1.req_valid = 1'b0;
    bus1.req_rw    = 1'b0;
    bus1.req_addr  = 5'd0;
    bus1.req_data  = 8'h00;
    bus3.req_valid = 1'b0;
    bus3.req_rw    = 1'b0;
    bus3.req_addr  = 5'd0;
    bus3.req_data  = 8'h00;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_bus");
    checkOutput("reset_init", {init_busy1, init_done1, init_err1}, 3'b000);
    checkOutput("dut3_reset", {bus3.CSn, bus3.E, bus3.D_oe, init_busy3, init_done3, init_err3},
                6'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(bus1.req_ready), 32'd1);
    k = e_rises;
    repeat (100) @(negedge clk);
    checkOutput("idle_e_quiet", 32'(e_rises - k), 32'd0);
    checkOutput("idle_bus", {bus1.CSn, bus1.E, bus1.D_oe}, 3'b100);

    applyStimulus(1'b0, 5'h0E, 8'hFA, 8'h00);
    applyStimulus(1'b0, 5'h0F, 8'hAD, 8'h00);
    applyStimulus(1'b1, 5'h0F, 8'h00, 8'hAD);
    applyStimulus(1'b0, 5'h15, 8'h3C, 8'h00);
    checkOutput("wrap_write", 32'(wlog[wlog_n - 1]), {19'd0, 5'h15, 8'h3C});

    // Read latency on the E_HALF=3 instance.
    @(negedge clk);
    bus3.req_valid = 1'b1;
    bus3.req_rw    = 1'b1;
    bus3.req_addr  = 5'h0F;
    k = 0;
    while (!bus3.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    bus3.req_valid = 1'b0;
    k = 1;
    while (!bus3.rsp_valid && k <= 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("eh3_latency", 32'(k), 32'd13);
    checkOutput("eh3_rsp_data", 32'(bus3.rsp_data), 32'hAD);

    // Init and a host write raised together; init must run first.
    base = wlog_n;
    @(negedge clk);
    init_start1    = 1'b1;
    bus1.req_valid = 1'b1;
    bus1.req_rw    = 1'b0;
    bus1.req_addr  = 5'h0C;
    bus1.req_data  = 8'h55;
    @(negedge clk);
    init_start1 = 1'b0;
    checkOutput("init_running", {init_busy1, bus1.req_ready}, 2'b10);
    cyc = 0;
    while (init_busy1 && cyc < 200) begin
      cyc++;
      init_start1 = (cyc == 10);
      @(negedge clk);
    end
    init_start1 = 1'b0;
    checkOutput("init_cycles", 32'(cyc), 32'(INIT_CYC));
    checkOutput("init_flags", {init_busy1, init_done1, init_err1}, 3'b010);
    checkOutput("post_init_ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    k = 1;
    while (!bus1.rsp_valid && k <= 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("held_req_latency", 32'(k), 32'd5);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("init_r%0d", i), 32'(wlog[base + i]), {19'd0, 5'(i), init_tab[i]});
    checkOutput("held_req_write", 32'(wlog[base + 16]), {19'd0, 5'h0C, 8'h55});

    // Reset asserted during D_EH of a write.
    base = wlog_n;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_rw    = 1'b0;
    bus1.req_addr  = 5'h03;
    bus1.req_data  = 8'h77;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_in_deh", {bus1.E, bus1.RS, bus1.D_out}, {1'b1, 1'b1, 8'h77});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rsp_seen = rsp_seen | bus1.rsp_valid;
    end
    rst_n = 1'b1;
    @(negedge clk);
    rsp_seen = rsp_seen | bus1.rsp_valid;
    checkOutput("abort_no_rsp", 32'(rsp_seen), 32'd0);
    checkOutput("abort_no_write", 32'(wlog_n - base), 32'd0);
    applyStimulus(1'b1, 5'h03, 8'h00, 8'h0C);

`ifdef CRTC_READBACK_VERIFY_EN
    force_r15 = 1'b1;
    run_init(cyc);
    checkOutput("rbv_cycles", 32'(cyc), 32'(INIT_CYC));
    checkOutput("rbv_flags", {init_busy1, init_done1, init_err1}, 3'b011);
    force_r15 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
